video_dac_gen: RTL

VIDEO_DAC_GEN -- requirements
Module: video_dac_gen

---
 rtl/video_dac_gen.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/video_dac_gen.sv
// Composite-video raster generator: line/frame counters, a pixel request pipe and a registered
// 4-bit DAC level. Define VIDEO_DAC_GEN_TEST_PATTERN_EN to replace pix_data_i with internal bars.
module video_dac_gen #(
  parameter int unsigned H_TOTAL  = 1024,
  parameter int unsigned H_SYNC   = 75,
  parameter int unsigned H_BACK   = 91,
  parameter int unsigned H_ACTIVE = 832,
  parameter int unsigned V_TOTAL  = 312,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_START  = 40,
  parameter int unsigned V_ACTIVE = 256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] pix_data_i,
  output logic       pix_req_o,
  output logic [9:0] pix_x_o,
  output logic [8:0] pix_y_o,
  output logic       frame_start_o,
  output logic [3:0] vdac_o
);

  localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0] HSyncEnd   = 10'(H_SYNC);
  localparam logic [9:0] HActStart  = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] HActEnd    = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] HVsyncEnd  = 10'(H_TOTAL - H_SYNC);
  localparam logic [8:0] VLast      = 9'(V_TOTAL - 1);
  localparam logic [8:0] VSyncEnd   = 9'(V_SYNC);
  localparam logic [8:0] VActStart  = 9'(V_START);
  localparam logic [8:0] VActEnd    = 9'(V_START + V_ACTIVE);

  localparam logic [3:0] LvlSync    = 4'd0;
  localparam logic [3:0] LvlBlank   = 4'd4;

  typedef enum logic [1:0] {ClsSync, ClsBlank, ClsPixel} cls_e;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [8:0] v_cnt_q, v_cnt_d;
  cls_e       cls0;
  cls_e       cls1_q;
  logic [9:0] pix_x_q, pix_x_d;
  logic [8:0] pix_y_q, pix_y_d;
  logic       frame_start_q, frame_start_d;
  logic [1:0] pix_code;
  logic [3:0] vdac_q, vdac_d;

  // Raster counters
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HLast) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 9'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Stage 0: classify the current counter position. Vsync lines use broad (inverted) sync.
  always_comb begin
    cls0 = ClsBlank;
    if (v_cnt_q < VSyncEnd) begin
      if (h_cnt_q < HVsyncEnd) cls0 = ClsSync;
    end else if (h_cnt_q < HSyncEnd) begin
      cls0 = ClsSync;
    end else if ((h_cnt_q >= HActStart) && (h_cnt_q < HActEnd) &&
                 (v_cnt_q >= VActStart) && (v_cnt_q < VActEnd)) begin
      cls0 = ClsPixel;
    end
  end

  // Stage 1: request and coordinates; coordinates hold between requests
  always_comb begin
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    if (cls0 == ClsPixel) begin
      pix_x_d = h_cnt_q - HActStart;
      pix_y_d = v_cnt_q - VActStart;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cls1_q        <= ClsBlank;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cls1_q        <= cls0;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VIDEO_DAC_GEN_TEST_PATTERN_EN
  localparam logic [9:0] Bar1 = 10'(H_ACTIVE / 4);
  localparam logic [9:0] Bar2 = 10'(H_ACTIVE / 2);
  localparam logic [9:0] Bar3 = 10'((3 * H_ACTIVE) / 4);

  logic unused_pix_data;
  assign unused_pix_data = ^pix_data_i;

  // Four equal-width vertical bars across the active line
  always_comb begin
    if (pix_x_q < Bar1) begin
      pix_code = 2'd0;
    end else if (pix_x_q < Bar2) begin
      pix_code = 2'd1;
    end else if (pix_x_q < Bar3) begin
      pix_code = 2'd2;
    end else begin
      pix_code = 2'd3;
    end
  end

  assign pix_req_o = 1'b0;
`else
  assign pix_code  = pix_data_i;
  assign pix_req_o = (cls1_q == ClsPixel);
`endif

  // Stage 2: DAC level; pix_code only matters when stage 1 held a pixel
  always_comb begin
    vdac_d = LvlBlank;
    unique case (cls1_q)
      ClsSync:  vdac_d = LvlSync;
      ClsPixel: begin
        unique case (pix_code)
          2'd0:    vdac_d = 4'd5;
          2'd1:    vdac_d = 4'd8;
          2'd2:    vdac_d = 4'd11;
          default: vdac_d = 4'd15;
        endcase
      end
      default:  vdac_d = LvlBlank;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vdac_q <= LvlBlank;
    end else begin
      vdac_q <= vdac_d;
    end
  end

  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
  assign frame_start_o = frame_start_q;
  assign vdac_o        = vdac_q;

endmodule
